// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier-sharing controller.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Worst-case serial multiply plus margin.
  function automatic int default_timeout(input int n);
    return 4 * n + 8;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arb.sv
// Combinational round-robin arbiter: first requester after ptr wins.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  always_comb begin
    logic [IDW-1:0] sel;
    sel       = '0;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      sel = IDW'((int'(ptr) + k) % NREQ);
      if (!any_valid && req[sel]) begin
        any_valid  = 1'b1;
        grant_idx  = sel;
        grant[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one serial multiplier among NREQ requesters with a tagged response
// channel and a watchdog that aborts and clears a stuck multiply.
//
// state | meaning
// IDLE  | arbitrate, accept one operand pair
// ISSUE | one-cycle start pulse to the multiplier
// WAIT  | wait for mul_end or watchdog expiry
// RESP  | hold response until rsp_ready
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int N       = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = default_timeout(N),
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_prod,
  output logic              rsp_err,
  output logic              mul_start,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  output logic              mul_clear,
  input  logic              mul_end,
  input  logic [2*N-1:0]    mul_prod
);

  localparam int CW = $clog2(TIMEOUT + 1);

  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("mult_share_ctrl: NREQ must be in 2..16");
  end

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, id_q;
  logic [N-1:0]    a_q, b_q;
  logic [2*N-1:0]  prod_q;
  logic            err_q;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            any_valid;
  logic [N-1:0]    a_arr [NREQ];
  logic [N-1:0]    b_arr [NREQ];
  logic [N-1:0]    sel_a, sel_b;
  logic            zero_op, timeout_hit;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[slice_lo(i, N) +: N];
    assign b_arr[i] = req_b[slice_lo(i, N) +: N];
  end

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  assign sel_a       = a_arr[grant_idx];
  assign sel_b       = b_arr[grant_idx];
  assign zero_op     = (sel_a == '0) || (sel_b == '0);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  assign mul_a    = a_q;
  assign mul_b    = b_q;
  assign rsp_id   = id_q;
  assign rsp_prod = prod_q;
  assign rsp_err  = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = zero_op ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mul_end || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    req_ready = '0;
    mul_start = 1'b0;
    mul_clear = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    if (!reset) req_ready = grant;
      ISSUE:   mul_start = 1'b1;
      WAIT:    mul_clear = timeout_hit && !mul_end;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr    <= IDW'(NREQ - 1);
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          id_q   <= grant_idx;
          ptr    <= grant_idx;
          prod_q <= '0;
          err_q  <= 1'b0;
          // Zero operands bypass the multiplier, so leave its inputs alone.
          if (!zero_op) begin
            a_q <= sel_a;
            b_q <= sel_b;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (cnt != CW'(TIMEOUT)) cnt <= cnt + CW'(1);
          if (mul_end) begin
            prod_q <= mul_prod;
            err_q  <= 1'b0;
          end else if (timeout_hit) begin
            prod_q <= '0;
            err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl with a behavioural serial multiplier.
module tb_mult_share_ctrl;

  localparam int N       = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 136;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [2*N-1:0]    rsp_prod;
  logic              rsp_err;
  logic              mul_start;
  logic [N-1:0]      mul_a, mul_b;
  logic              mul_clear;
  logic              mul_end = 1'b0;
  logic [2*N-1:0]    mul_prod = '0;

  mult_share_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_prod(rsp_prod), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_clear(mul_clear),
    .mul_end(mul_end), .mul_prod(mul_prod)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] prod;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          acc_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          issued[NREQ] = '{default: 0};
  int          accepted[NREQ] = '{default: 0};
  logic [31:0] opa[NREQ] = '{default: '0};
  logic [31:0] opb[NREQ] = '{default: '0};
  int          acc_cyc = 0;
  int          rsp_lat = 0;
  logic        rsp_v_prev = 1'b0;

  // multiplier model state
  int          m_lat = 3;
  logic        m_hang = 1'b0;
  logic        force_end = 1'b0;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_stable_bad = 1'b0;
  int          start_cnt = 0, start_cyc = 0;
  int          clear_cnt = 0, clear_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < NREQ; i++) p += issued[i] - accepted[i];
    return p;
  endfunction

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    opa[i] = a;
    opb[i] = b;
    issued[i]++;
  endtask

  task automatic expect_rsp(input logic [1:0] id, input logic [63:0] prod, input logic err);
    exp_t e;
    e.id = id; e.prod = prod; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pending() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drained"}, 64'(n < budget), 64'd1);
    repeat (2) @(negedge clock);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = (issued[i] > accepted[i]);
      req_a[i*N +: N]   = opa[i];
      req_b[i*N +: N]   = opb[i];
    end
  end

  initial forever begin
    logic hit;
    @(negedge clock);
    if (reset) begin
      m_busy = 1'b0;
    end else begin
      if (mul_clear) begin
        clear_cnt++;
        clear_cyc = cyc;
        m_busy = 1'b0;
      end
      if (mul_start) begin
        m_busy = 1'b1; m_a = mul_a; m_b = mul_b; m_cnt = m_lat;
        m_stable_bad = 1'b0;
        start_cnt++;
        start_cyc = cyc;
      end else if (m_busy && (mul_a !== m_a || mul_b !== m_b)) begin
        m_stable_bad = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    hit = 1'b0;
    if (m_busy && !m_hang) begin
      m_cnt--;
      if (m_cnt == 0) begin
        hit = 1'b1;
        m_busy = 1'b0;
      end
    end
    mul_end  = hit | force_end;
    mul_prod = hit ? 64'(m_a) * 64'(m_b) : 64'h0;
  end

  always @(negedge clock) begin
    if (reset) begin
      rsp_v_prev = 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) begin
          check("ready_onehot", 64'($countones(req_ready)), 64'd1);
          accepted[i]++;
          acc_q.push_back(i);
          acc_cyc = cyc;
        end
      if (rsp_valid && !rsp_v_prev) rsp_lat = cyc - acc_cyc;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual id=%0d prod=%0h err=%0b required=none",
                   rsp_id, rsp_prod, rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
          check("rsp_prod", rsp_prod, mon_e.prod);
          check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        end
      end
      rsp_v_prev = rsp_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int base, sbase, cbase, n;
    int ord[5];
    logic [1:0]  hold_id;
    logic [63:0] hold_prod;
    logic        hold_err, bp_bad, rdy_bad, late_bad;

    reset = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
    check("rst_rsp_prod", rsp_prod, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // fairness: ptr starts at 3 so order is 0,1,2,3 then 0 again
    base = acc_q.size();
    issue(0, 32'd3, 32'd5); issued[0]++;
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2, 32'd1000, 32'd1000);
    issue(3, 32'h0001_0000, 32'h0001_0000);
    expect_rsp(2'd0, 64'd15, 1'b0);
    expect_rsp(2'd1, 64'hFFFF_FFFE_0000_0001, 1'b0);
    expect_rsp(2'd2, 64'd1000000, 1'b0);
    expect_rsp(2'd3, 64'h1_0000_0000, 1'b0);
    expect_rsp(2'd0, 64'd15, 1'b0);
    wait_drain(300, "fair");
    ord = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++)
      check($sformatf("fair_order%0d", k), 64'(acc_q[base+k]), 64'(ord[k]));

    // single op, latency 3 multiplier
    sbase = start_cnt;
    issue(2, 32'd7, 32'd9);
    expect_rsp(2'd2, 64'd63, 1'b0);
    wait_drain(100, "single");
    check("single_starts", 64'(start_cnt - sbase), 64'd1);
    check("single_mul_ab", {m_a, m_b}, {32'd7, 32'd9});
    check("single_ab_stable", 64'(m_stable_bad), 64'd0);
    check("single_latency", 64'(rsp_lat), 64'd5);

    // zero-operand shortcut
    sbase = start_cnt;
    issue(1, 32'd0, 32'd5);
    expect_rsp(2'd1, 64'd0, 1'b0);
    wait_drain(100, "zero");
    check("zero_no_start", 64'(start_cnt - sbase), 64'd0);
    check("zero_latency", 64'(rsp_lat), 64'd1);

    // watchdog abort
    m_hang = 1'b1;
    cbase = clear_cnt;
    issue(2, 32'd5, 32'd5);
    expect_rsp(2'd2, 64'd0, 1'b1);
    wait_drain(400, "wdog");
    m_hang = 1'b0;
    check("wdog_clear_pulses", 64'(clear_cnt - cbase), 64'd1);
    check("wdog_cycles", 64'(clear_cyc - start_cyc), 64'(TIMEOUT));
    late_bad = 1'b0;
    force_end = 1'b1;
    @(negedge clock);
    force_end = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (rsp_valid) late_bad = 1'b1;
    end
    check("late_end_ignored", 64'(late_bad), 64'd0);

    // backpressure: response held 20 cycles while another request waits
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    issue(1, 32'd6, 32'd7);
    expect_rsp(2'd1, 64'd42, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    hold_id = rsp_id; hold_prod = rsp_prod; hold_err = rsp_err;
    issue(3, 32'd11, 32'd13);
    expect_rsp(2'd3, 64'd143, 1'b0);
    bp_bad = 1'b0;
    rdy_bad = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (!rsp_valid || rsp_id !== hold_id || rsp_prod !== hold_prod || rsp_err !== hold_err)
        bp_bad = 1'b1;
      if (req_ready !== '0) rdy_bad = 1'b1;
    end
    check("bp_fields_stable", 64'(bp_bad), 64'd0);
    check("bp_ready_low", 64'(rdy_bad), 64'd0);
    check("bp_held_prod", hold_prod, 64'd42);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    wait_drain(100, "bp");

    // mul_end on the timeout cycle wins
    m_lat = TIMEOUT;
    cbase = clear_cnt;
    issue(0, 32'd1000, 32'd3);
    expect_rsp(2'd0, 64'd3000, 1'b0);
    wait_drain(400, "race");
    check("race_no_clear", 64'(clear_cnt - cbase), 64'd0);
    check("race_ab_stable", 64'(m_stable_bad), 64'd0);
    m_lat = 3;

    // reset in the middle of WAIT
    m_hang = 1'b1;
    sbase = start_cnt;
    issue(2, 32'd4, 32'd4);
    n = 0;
    while (start_cnt == sbase && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("rstwait_started", 64'(start_cnt - sbase), 64'd1);
    repeat (5) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rstwait_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstwait_ctrl", {req_ready, mul_start, mul_clear}, 64'd0);
    check("rstwait_mul_ab", {mul_a, mul_b}, 64'd0);
    check("rstwait_rsp", {rsp_prod[61:0], rsp_id}, 64'd0);
    m_hang = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    base = acc_q.size();
    issue(3, 32'd9, 32'd9);
    issue(0, 32'd7, 32'd8);
    expect_rsp(2'd0, 64'd56, 1'b0);
    expect_rsp(2'd3, 64'd81, 1'b0);
    wait_drain(200, "rstwait");
    check("rstwait_first", 64'(acc_q[base]), 64'd0);
    check("rstwait_second", 64'(acc_q[base+1]), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
